// File: rtl/usb_host_sched.sv
// Host-mode USB transaction scheduler: round-robin arbitration over NREQ requesters,
// then token / data / handshake sequencing with timeout retries and a status return.
module usb_host_sched #(
    parameter int NREQ      = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_dir,
    input  logic [7*NREQ-1:0]    req_addr,
    input  logic [4*NREQ-1:0]    req_endp,
    output logic [NREQ-1:0]      req_grant,
    output logic [NREQ-1:0]      req_done,
    output logic [2:0]           req_status,
    output logic [3:0]           tx_pid,
    output logic [6:0]           tx_addr,
    output logic [3:0]           tx_endp,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic                 tx_lt_valid,
    input  logic                 tx_lt_ready,
    input  logic                 tx_lt_eop,
    input  logic                 rx_lt_valid,
    input  logic                 rx_lt_ready,
    input  logic                 rx_lt_eop,
    input  logic                 rx_pid_en,
    input  logic [3:0]           rx_pid,
    input  logic                 time_out,
    output logic                 busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [2:0] ST_ACK      = 3'd0;
    localparam logic [2:0] ST_NAK      = 3'd1;
    localparam logic [2:0] ST_STALL    = 3'd2;
    localparam logic [2:0] ST_TIMEOUT  = 3'd3;
    localparam logic [2:0] ST_PROTOCOL = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_TOKEN, S_DOUT, S_HS_WAIT,
        S_DIN_WAIT, S_DIN_BODY, S_ACK_TX, S_DONE
    } state_t;

    state_t          state_reg;
    logic [PW-1:0]   rr_ptr_reg;
    logic [PW-1:0]   idx_reg;
    logic            dir_reg;
    logic [3:0]      retry_cnt_reg;

    logic [6:0]      addr_arr [NREQ];
    logic [3:0]      endp_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[7*gi +: 7];
            assign endp_arr[gi] = req_endp[4*gi +: 4];
        end
    endgenerate

    // First valid requester at or after rr_ptr, wrapping past NREQ-1.
    logic            arb_found;
    logic [PW-1:0]   arb_idx;
    always_comb begin
        int cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(rr_ptr_reg) + k) % NREQ;
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand[PW-1:0];
            end
        end
    end

    logic [NREQ-1:0] arb_onehot;
    logic [PW-1:0]   idx_wrap;
    logic            retry_ok;
    logic [3:0]      token_pid;

    assign arb_onehot = NREQ'(1) << arb_idx;
    assign idx_wrap   = (idx_reg == PW'(NREQ-1)) ? '0 : idx_reg + 1'b1;
    assign retry_ok   = (retry_cnt_reg < 4'(MAX_RETRY));
    assign token_pid  = dir_reg ? PID_IN : PID_OUT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            rr_ptr_reg    <= '0;
            idx_reg       <= '0;
            dir_reg       <= 1'b0;
            retry_cnt_reg <= '0;
            req_grant     <= '0;
            req_done      <= '0;
            req_status    <= '0;
            tx_pid        <= '0;
            tx_addr       <= '0;
            tx_endp       <= '0;
            tx_valid      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            req_done <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (|req_valid) begin
                        state_reg <= S_ARB;
                        busy      <= 1'b1;
                    end
                end
                S_ARB: begin
                    // A request withdrawn before arbitration simply returns us to IDLE.
                    if (arb_found) begin
                        idx_reg       <= arb_idx;
                        dir_reg       <= req_dir[arb_idx];
                        retry_cnt_reg <= '0;
                        req_grant     <= arb_onehot;
                        tx_valid      <= 1'b1;
                        tx_pid        <= req_dir[arb_idx] ? PID_IN : PID_OUT;
                        tx_addr       <= addr_arr[arb_idx];
                        tx_endp       <= endp_arr[arb_idx];
                        state_reg     <= S_TOKEN;
                    end else begin
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
                S_TOKEN: begin
                    if (tx_ready) begin
                        tx_valid  <= 1'b0;
                        state_reg <= dir_reg ? S_DIN_WAIT : S_DOUT;
                    end
                end
                S_DOUT: begin
                    if (tx_lt_valid && tx_lt_ready && tx_lt_eop)
                        state_reg <= S_HS_WAIT;
                end
                S_HS_WAIT: begin
                    if (rx_pid_en) begin
                        req_done  <= req_grant;
                        state_reg <= S_DONE;
                        case (rx_pid)
                            PID_ACK:   req_status <= ST_ACK;
                            PID_NAK:   req_status <= ST_NAK;
                            PID_STALL: req_status <= ST_STALL;
                            default:   req_status <= ST_PROTOCOL;
                        endcase
                    end else if (time_out) begin
                        if (retry_ok) begin
                            retry_cnt_reg <= retry_cnt_reg + 4'd1;
                            tx_valid      <= 1'b1;
                            tx_pid        <= token_pid;
                            state_reg     <= S_TOKEN;
                        end else begin
                            req_status <= ST_TIMEOUT;
                            req_done   <= req_grant;
                            state_reg  <= S_DONE;
                        end
                    end
                end
                S_DIN_WAIT: begin
                    if (rx_pid_en) begin
                        if (rx_pid == PID_DATA0 || rx_pid == PID_DATA1) begin
                            state_reg <= S_DIN_BODY;
                        end else begin
                            req_done  <= req_grant;
                            state_reg <= S_DONE;
                            case (rx_pid)
                                PID_NAK:   req_status <= ST_NAK;
                                PID_STALL: req_status <= ST_STALL;
                                default:   req_status <= ST_PROTOCOL;
                            endcase
                        end
                    end else if (time_out) begin
                        if (retry_ok) begin
                            retry_cnt_reg <= retry_cnt_reg + 4'd1;
                            tx_valid      <= 1'b1;
                            tx_pid        <= token_pid;
                            state_reg     <= S_TOKEN;
                        end else begin
                            req_status <= ST_TIMEOUT;
                            req_done   <= req_grant;
                            state_reg  <= S_DONE;
                        end
                    end
                end
                S_DIN_BODY: begin
                    if (rx_lt_valid && rx_lt_ready && rx_lt_eop) begin
                        tx_valid  <= 1'b1;
                        tx_pid    <= PID_ACK;
                        state_reg <= S_ACK_TX;
                    end
                end
                S_ACK_TX: begin
                    if (tx_ready) begin
                        tx_valid   <= 1'b0;
                        req_status <= ST_ACK;
                        req_done   <= req_grant;
                        state_reg  <= S_DONE;
                    end
                end
                S_DONE: begin
                    req_grant  <= '0;
                    rr_ptr_reg <= idx_wrap;
                    busy       <= 1'b0;
                    state_reg  <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usb_host_sched.sv
// Directed bench for usb_host_sched: one task per scenario, inline expected-value checks.
module tb_usb_host_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_dir = '0;
    logic [27:0] req_addr = '0;
    logic [15:0] req_endp = '0;
    logic [3:0]  req_grant, req_done;
    logic [2:0]  req_status;
    logic [3:0]  tx_pid, tx_endp;
    logic [6:0]  tx_addr;
    logic        tx_valid, busy;
    logic        tx_ready = 0;
    logic        tx_lt_valid = 0, tx_lt_ready = 0, tx_lt_eop = 0;
    logic        rx_lt_valid = 0, rx_lt_ready = 0, rx_lt_eop = 0;
    logic        rx_pid_en = 0;
    logic [3:0]  rx_pid = '0;
    logic        time_out = 0;

    int vectors = 0;
    int miscompares = 0;

    usb_host_sched #(.NREQ(4), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dir(req_dir), .req_addr(req_addr), .req_endp(req_endp),
        .req_grant(req_grant), .req_done(req_done), .req_status(req_status),
        .tx_pid(tx_pid), .tx_addr(tx_addr), .tx_endp(tx_endp),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_lt_valid(tx_lt_valid), .tx_lt_ready(tx_lt_ready), .tx_lt_eop(tx_lt_eop),
        .rx_lt_valid(rx_lt_valid), .rx_lt_ready(rx_lt_ready), .rx_lt_eop(rx_lt_eop),
        .rx_pid_en(rx_pid_en), .rx_pid(rx_pid), .time_out(time_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---- stimulus helpers (no checking inside) ----
    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_dir = '0; req_addr = '0; req_endp = '0;
        tx_ready = 0; rx_pid_en = 0; time_out = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_tx(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx_valid === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output bit ok, output logic [3:0] dv, output logic [2:0] st,
                             output bit saw_tx);
        ok = 0; dv = '0; st = '0; saw_tx = 0;
        for (int i = 0; i < 50; i++) begin
            if (req_done !== 4'b0000) begin
                ok = 1; dv = req_done; st = req_status;
                break;
            end
            if (tx_valid === 1'b1) saw_tx = 1;
            @(negedge clk);
        end
    endtask

    task automatic tok_handshake();
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic out_eop();
        tx_lt_valid = 1; tx_lt_ready = 1; tx_lt_eop = 1;
        @(negedge clk);
        tx_lt_valid = 0; tx_lt_ready = 0; tx_lt_eop = 0;
    endtask

    task automatic in_beat(input bit eop);
        rx_lt_valid = 1; rx_lt_ready = 1; rx_lt_eop = eop;
        @(negedge clk);
        rx_lt_valid = 0; rx_lt_ready = 0; rx_lt_eop = 0;
    endtask

    task automatic pulse_pid(input logic [3:0] pid, input bit with_to);
        rx_pid_en = 1; rx_pid = pid; time_out = with_to;
        @(negedge clk);
        rx_pid_en = 0; time_out = 0;
    endtask

    task automatic pulse_timeout();
        time_out = 1;
        @(negedge clk);
        time_out = 0;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        do_reset();
        vectors++;
        if ({req_grant, req_done, req_status, tx_pid, tx_addr, tx_endp, tx_valid, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got grant=%b done=%b st=%0d pid=%b addr=%h endp=%h txv=%b busy=%b, expected all 0",
                     req_grant, req_done, req_status, tx_pid, tx_addr, tx_endp, tx_valid, busy);
        end
        $display("test_reset: outputs checked after reset");
    endtask

    task automatic test_out_ack();
        bit ok, saw; logic [3:0] dv; logic [2:0] st;
        do_reset();
        req_valid = 4'b0001; req_dir = 4'b0000;
        req_addr[6:0] = 7'h05; req_endp[3:0] = 4'h1;
        @(negedge clk);
        vectors++;
        if (tx_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL out_arb_cycle: got txv=%b busy=%b, expected txv=0 busy=1", tx_valid, busy);
        end
        @(negedge clk);
        vectors++;
        if (tx_valid !== 1'b1 || tx_pid !== 4'b0001 || tx_addr !== 7'h05 || tx_endp !== 4'h1 || req_grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL out_token: got txv=%b pid=%b addr=%h endp=%h grant=%b, expected 1 0001 05 1 0001",
                     tx_valid, tx_pid, tx_addr, tx_endp, req_grant);
        end
        @(negedge clk);  // not ready yet: token must hold
        vectors++;
        if (tx_valid !== 1'b1 || tx_pid !== 4'b0001) begin
            miscompares++;
            $display("FAIL out_token_hold: got txv=%b pid=%b, expected 1 0001", tx_valid, tx_pid);
        end
        tok_handshake();
        vectors++;
        if (tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL out_token_drop: got txv=%b, expected 0", tx_valid);
        end
        out_eop();
        pulse_pid(4'b0010, 0);
        wait_done(ok, dv, st, saw);
        vectors++;
        if (!ok || dv !== 4'b0001 || st !== 3'd0 || req_grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL out_ack_done: got ok=%0d done=%b st=%0d grant=%b, expected 1 0001 0 0001", ok, dv, st, req_grant);
        end
        // rr_ptr now 1: with requesters 0 and 3 pending, 3 wins; token no earlier than 3 cycles
        req_valid = 4'b1001;
        req_addr[27:21] = 7'h33;
        @(negedge clk);
        vectors++;
        if (req_grant !== 4'b0000 || tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL out_grant_release: got grant=%b txv=%b, expected 0000 0", req_grant, tx_valid);
        end
        @(negedge clk);
        vectors++;
        if (tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL out_min_gap: got txv=%b two cycles after done, expected 0", tx_valid);
        end
        @(negedge clk);
        vectors++;
        if (tx_valid !== 1'b1 || req_grant !== 4'b1000 || tx_addr !== 7'h33) begin
            miscompares++;
            $display("FAIL out_rr_next: got txv=%b grant=%b addr=%h, expected 1 1000 33", tx_valid, req_grant, tx_addr);
        end
        $display("test_out_ack: OUT/ACK transaction and rr pointer advance checked");
    endtask

    task automatic test_in_data();
        bit ok, saw; logic [3:0] dv; logic [2:0] st;
        do_reset();
        req_valid = 4'b0100; req_dir = 4'b0100;
        req_addr[20:14] = 7'h12; req_endp[11:8] = 4'h3;
        wait_tx(ok);
        vectors++;
        if (!ok || tx_pid !== 4'b1001 || tx_addr !== 7'h12 || tx_endp !== 4'h3 || req_grant !== 4'b0100) begin
            miscompares++;
            $display("FAIL in_token: got ok=%0d pid=%b addr=%h endp=%h grant=%b, expected 1 1001 12 3 0100",
                     ok, tx_pid, tx_addr, tx_endp, req_grant);
        end
        tok_handshake();
        pulse_pid(4'b1011, 0);
        for (int b = 0; b < 7; b++) in_beat(0);
        pulse_pid(4'b1010, 0);  // stray PID during body must be ignored
        vectors++;
        if (tx_valid !== 1'b0 || req_done !== 4'b0000) begin
            miscompares++;
            $display("FAIL in_body_wait: got txv=%b done=%b, expected 0 0000", tx_valid, req_done);
        end
        in_beat(1);
        wait_tx(ok);
        vectors++;
        if (!ok || tx_pid !== 4'b0010 || req_grant !== 4'b0100) begin
            miscompares++;
            $display("FAIL in_ack_tx: got ok=%0d pid=%b grant=%b, expected 1 0010 0100", ok, tx_pid, req_grant);
        end
        tok_handshake();
        req_addr[20:14] = 7'h7E;  // latched fields must not follow inputs
        wait_done(ok, dv, st, saw);
        vectors++;
        if (!ok || dv !== 4'b0100 || st !== 3'd0 || tx_addr !== 7'h12) begin
            miscompares++;
            $display("FAIL in_done: got ok=%0d done=%b st=%0d addr=%h, expected 1 0100 0 12", ok, dv, st, tx_addr);
        end
        $display("test_in_data: IN/DATA1 burst with ACK checked");
    endtask

    task automatic test_round_robin();
        bit ok, saw; logic [3:0] dv, exp_g; logic [2:0] st;
        do_reset();
        req_valid = 4'b1111; req_dir = 4'b0000;
        req_addr = {7'h13, 7'h12, 7'h11, 7'h10};
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            wait_tx(ok);
            vectors++;
            if (!ok || req_grant !== exp_g || tx_addr !== 7'(7'h10 + (k % 4))) begin
                miscompares++;
                $display("FAIL rr_grant_%0d: got ok=%0d grant=%b addr=%h, expected 1 %b %h",
                         k, ok, req_grant, tx_addr, exp_g, 7'(7'h10 + (k % 4)));
            end
            tok_handshake();
            out_eop();
            pulse_pid(4'b0010, 0);
            wait_done(ok, dv, st, saw);
            vectors++;
            if (!ok || dv !== exp_g || st !== 3'd0) begin
                miscompares++;
                $display("FAIL rr_done_%0d: got ok=%0d done=%b st=%0d, expected 1 %b 0", k, ok, dv, st, exp_g);
            end
            @(negedge clk);
        end
        $display("test_round_robin: grant order 0,1,2,3,0 checked");
    endtask

    task automatic test_timeout();
        bit ok, saw; logic [3:0] dv; logic [2:0] st;
        int tokens = 0;
        do_reset();
        req_valid = 4'b0010; req_dir = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            wait_tx(ok);
            if (ok) tokens++;
            tok_handshake();
            out_eop();
            pulse_timeout();
        end
        wait_done(ok, dv, st, saw);
        vectors++;
        if (tokens != 4 || !ok || dv !== 4'b0010 || st !== 3'd3 || saw) begin
            miscompares++;
            $display("FAIL timeout_exhaust: got tokens=%0d ok=%0d done=%b st=%0d extra_tx=%0d, expected 4 1 0010 3 0",
                     tokens, ok, dv, st, saw);
        end
        $display("test_timeout: 4 tokens then TIMEOUT checked");
    endtask

    task automatic test_in_errors();
        bit ok, saw; logic [3:0] dv; logic [2:0] st;
        logic [3:0] pids [3] = '{4'b1010, 4'b1110, 4'b0010};
        logic [2:0] exp_st [3] = '{3'd1, 3'd2, 3'd4};
        do_reset();
        req_valid = 4'b1000; req_dir = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            wait_tx(ok);
            tok_handshake();
            pulse_pid(pids[k], k == 0);  // first case also raises time_out: PID must win
            wait_done(ok, dv, st, saw);
            vectors++;
            if (!ok || dv !== 4'b1000 || st !== exp_st[k] || saw) begin
                miscompares++;
                $display("FAIL in_err_%0d: got ok=%0d done=%b st=%0d ack_tx=%0d, expected 1 1000 %0d 0",
                         k, ok, dv, st, saw, exp_st[k]);
            end
            @(negedge clk);
        end
        $display("test_in_errors: NAK/STALL/PROTOCOL on IN checked");
    endtask

    task automatic test_reset_mid_dout();
        bit ok;
        bit done_seen = 0;
        do_reset();
        req_valid = 4'b0001; req_dir = 4'b0000;
        wait_tx(ok);
        tok_handshake();
        rst = 1'b1;
        req_valid = 4'b0100;
        #1;
        vectors++;
        if (req_grant !== 4'b0000 || tx_valid !== 1'b0 || busy !== 1'b0 || req_done !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_async: got grant=%b txv=%b busy=%b done=%b, expected 0000 0 0 0000",
                     req_grant, tx_valid, busy, req_done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_done !== 4'b0000) done_seen = 1;
            if (tx_valid === 1'b1) break;
            @(negedge clk);
        end
        vectors++;
        if (tx_valid !== 1'b1 || req_grant !== 4'b0100 || done_seen) begin
            miscompares++;
            $display("FAIL rst_regrant: got txv=%b grant=%b done_seen=%0d, expected 1 0100 0",
                     tx_valid, req_grant, done_seen);
        end
        $display("test_reset_mid_dout: async abort and re-arbitration checked");
    endtask

    initial begin
        test_reset();
        test_out_ack();
        test_in_data();
        test_round_robin();
        test_timeout();
        test_in_errors();
        test_reset_mid_dout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
